digit_serial_adder: RTL
=======================

# digit_serial_adder

Multi-cycle, parametrised two's-complement adder/subtractor. It processes WIDTH-bit operands DIGIT bits per clock with a registered inter-digit carry, trading latency for area. A start/busy/done handshake connects it to the datapath control. It is the sequential, wide-word successor to the single-bit full adder cell, and adds a subtract mode plus carry and signed-overflow flags.

## Interface
- WIDTH, 32: operand and result width in bits.
- DIGIT, 4: bits processed per cycle.
  - Must be ≥1 and divide WIDTH exactly.
  - N = WIDTH/DIGIT is the number of digit cycles.
- clk  input  1  rising-edge clock; the block uses one clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  WIDTH  operand A; latched when start is accepted.
- B  input  WIDTH  operand B; latched when start is accepted.
- Sub  input  1  mode, latched with the operands: 0 = A+B, 1 = A−B.
- busy  output  1  high while digits are being processed (RUN).
- done  output  1  one-cycle pulse when a result is committed.
- Sum  output  WIDTH  result, registered and held.
- Cout  output  1  carry out of the MSB. In Sub mode, 1 means no borrow (A ≥ B unsigned).
- Overflow  output  1  signed overflow of the operation.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: capture the operands into internal shift registers.
  - a_r = A.
  - b_r = Sub ? ~B : B.
  - carry = Sub.
  - Capture the MSBs for the overflow check.
  - Set digit count = 0 and go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - Compute {c, s} = a_r[DIGIT-1:0] + b_r[DIGIT-1:0] + carry.
  - Shift s into the top of an internal result shift register (LSB digit first).
  - Shift a_r and b_r right by DIGIT, update carry = c, and increment the count.
- RUN, on the N-th digit: go to DONE.
  - Load Sum with the completed result and Cout with the final carry.
  - Load Overflow = (a_msb == b_eff_msb) && (Sum[WIDTH-1] != a_msb), where b_eff = B or ~B per the mode.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in RUN and DONE; no queuing, no error flag.
- A, B and Sub may change freely after acceptance without affecting the operation in flight.
- Sum, Cout and Overflow change only on commit (the RUN→DONE edge). Otherwise they hold the previous result, including while busy.
- All arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Reset (rst_n=0, asynchronous): state = IDLE; busy = 0, done = 0, Sum = 0, Cout = 0, Overflow = 0; internal registers and count cleared.
- Reset mid-RUN aborts the operation. No done is produced, and outputs return to their reset values.
- Release of rst_n is synchronous to clk. The first start can be accepted on the first rising edge after release.
- Start accepted at edge E0:
  - busy = 1 from after E0 through after E0+N−1.
  - The result commits at edge E0+N; busy drops and done = 1 for the cycle following E0+N.
  - Back in IDLE after E0+N+1.
- Latency from the start edge to the done cycle: N cycles. Throughput: one operation per N+2 cycles.
- A start asserted during the done cycle is ignored. The next acceptance is possible at edge E0+N+2.
- Back-to-back: holding start high continuously restarts at every IDLE visit, using the operands present at that edge.
- busy and done are never high in the same cycle.

## Test plan
- Add wrap, WIDTH=8, DIGIT=4 (N=2): A=0xFF, B=0x01, Sub=0.
  - Sum=0x00, Cout=1, Overflow=0.
  - busy high 2 cycles; done exactly 2 cycles after the start edge.
- Signed add overflow: A=0x7F, B=0x01, Sub=0 → Sum=0x80, Cout=0, Overflow=1.
- Subtract with borrow: A=0x05, B=0x07, Sub=1 → Sum=0xFE, Cout=0, Overflow=0.
- Subtract with overflow: A=0x80, B=0x01, Sub=1 → Sum=0x7F, Cout=1, Overflow=1.
- Digit-size sweep: DIGIT=1 (N=8) and DIGIT=8 (N=1).
  - A=0x3C, B=0x5A, Sub=0 → Sum=0x96, Cout=0, Overflow=1.
  - Latencies: 8 cycles for DIGIT=1, 1 cycle for DIGIT=8.
  - Compare each against a random 1000-vector golden model.
- Control corners:
  - Pulse start again and change A/B mid-RUN → ignored; result matches the originally latched operands.
  - Drop rst_n mid-RUN → outputs immediately 0, no done.
  - Next start after release completes normally.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement adder/subtractor: WIDTH-bit operands are
// consumed DIGIT bits per clock, LSB digit first, with a registered carry.
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_b_eff;
  logic [DIGIT:0]   w_digit_sum;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;
  logic             w_ovf_next;

  // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
  assign w_b_eff     = Sub ? ~B : B;
  assign w_digit_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, r_carry};
  assign w_res_next  = (r_res >> DIGIT)
                     | (WIDTH'(w_digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_last      = (r_cnt == CW'(N - 1));
  assign w_ovf_next  = (r_a_msb == r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand capture and per-digit shift/accumulate datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_res   <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= w_b_eff;
            r_carry <= Sub;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= w_b_eff[WIDTH-1];
            r_cnt   <= {CW{1'b0}};
          end else begin
            r_cnt   <= r_cnt;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_digit_sum[DIGIT];
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
        default: begin
          r_cnt   <= r_cnt;
        end
      endcase
    end
  end

  // Registered status flags and result commit on the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      Sum      <= {WIDTH{1'b0}};
      Cout     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      busy <= (w_next_state == S_RUN);
      done <= (w_next_state == S_DONE);
      if ((r_state == S_RUN) && w_last) begin
        Sum      <= w_res_next;
        Cout     <= w_digit_sum[DIGIT];
        Overflow <= w_ovf_next;
      end else begin
        Sum      <= Sum;
        Cout     <= Cout;
        Overflow <= Overflow;
      end
    end
  end

endmodule
